// File: rtl/output_sched4.sv
// output_sched4: 4-input round-robin output-port scheduler with credit-based
// flow control toward the downstream input buffer. The winning packet is
// registered onto the output link with one cycle of latency.
module output_sched4 #(
    parameter int unsigned WIDTH_packet = 57,
    parameter int unsigned CREDITS      = 4,
    parameter int unsigned CW           = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [3:0]                in_valid,
    input  logic [4*WIDTH_packet-1:0] in_data,
    output logic [3:0]                in_ready,
    output logic                      out_valid,
    output logic [WIDTH_packet-1:0]   out_data,
    output logic [1:0]                out_src,
    input  logic                      credit_return,
    output logic [CW-1:0]             credit_cnt,
    output logic                      credit_err
);

    localparam int unsigned NPORT = 4;
    localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDITS);

    logic [CW-1:0]           r_credit_cnt;
    logic [1:0]              r_rr_ptr;
    logic                    r_out_valid;
    logic [WIDTH_packet-1:0] r_out_data;
    logic [1:0]              r_out_src;
    logic                    r_credit_err;

    logic                    w_can_grant;
    logic [NPORT-1:0]        w_req;
    logic [NPORT-1:0]        w_rot;
    logic [1:0]              w_off;
    logic                    w_found;
    logic [1:0]              w_win;
    logic [WIDTH_packet-1:0] w_data;
    logic [CW-1:0]           w_cnt_next;
    logic                    w_overflow;

    // Requests are only eligible with a registered credit and outside reset.
    assign w_can_grant = ~reset & (r_credit_cnt != '0);
    assign w_req       = in_valid & {NPORT{w_can_grant}};

    // Rotate so bit 0 is the highest-priority port, then pick the first set bit.
    assign w_rot = 4'({w_req, w_req} >> r_rr_ptr);

    // Priority encode the rotated request vector.
    always_comb begin
        w_off   = 2'd0;
        w_found = 1'b0;
        for (int k = 0; k < NPORT; k++) begin
            if (!w_found && w_rot[k]) begin
                w_off   = 2'(k);
                w_found = 1'b1;
            end
        end
    end

    assign w_win    = 2'(r_rr_ptr + w_off);
    assign in_ready = w_found ? (4'b0001 << w_win) : 4'b0000;

    // Select the winning packet from the flattened input bus.
    always_comb begin
        w_data = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (w_win == 2'(i)) begin
                w_data = in_data[i*WIDTH_packet +: WIDTH_packet];
            end
        end
    end

    // Credit bookkeeping: grant consumes, return refills, both cancel out.
    always_comb begin
        w_cnt_next = r_credit_cnt;
        w_overflow = 1'b0;
        if (w_found && !credit_return) begin
            w_cnt_next = r_credit_cnt - CW'(1);
        end else if (!w_found && credit_return) begin
            if (r_credit_cnt == CREDIT_MAX) begin
                w_overflow = 1'b1;
            end else begin
                w_cnt_next = r_credit_cnt + CW'(1);
            end
        end
    end

    // Output register, round-robin pointer and credit state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_credit_cnt <= CREDIT_MAX;
            r_rr_ptr     <= 2'd0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_src    <= 2'd0;
            r_credit_err <= 1'b0;
        end else begin
            r_credit_cnt <= w_cnt_next;
            r_out_valid  <= w_found;
            if (w_found) begin
                r_out_data <= w_data;
                r_out_src  <= w_win;
                r_rr_ptr   <= 2'(w_win + 2'd1);
            end
            if (w_overflow) begin
                r_credit_err <= 1'b1;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_src    = r_out_src;
    assign credit_cnt = r_credit_cnt;
    assign credit_err = r_credit_err;

endmodule

// File: tb/tb_output_sched4.sv
// Directed table-driven bench for output_sched4.
module tb_output_sched4;

    localparam int unsigned W  = 57;
    localparam int unsigned CR = 4;
    localparam int unsigned CW = 4;

    logic            clk;
    logic            reset;
    logic [3:0]      in_valid;
    logic [4*W-1:0]  in_data;
    logic [3:0]      in_ready;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic [1:0]      out_src;
    logic            credit_return;
    logic [CW-1:0]   credit_cnt;
    logic            credit_err;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [3:0] valid;
        logic       ret;
        logic [3:0] ready;
        logic       ov;
        logic [1:0] src;
        logic       chk_d;
        logic [3:0] cnt;
        logic       err;
    } vec_t;

    vec_t vecs[25];

    output_sched4 #(.WIDTH_packet(W), .CREDITS(CR), .CW(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_src      (out_src),
        .credit_return(credit_return),
        .credit_cnt   (credit_cnt),
        .credit_err   (credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-port packet pattern: 0x0AA.., 0x0BB.., 0x0CC.., 0x0DD..
    function automatic logic [W-1:0] pat(input logic [1:0] p);
        logic [7:0] b;
        case (p)
            2'd0:    b = 8'hAA;
            2'd1:    b = 8'hBB;
            2'd2:    b = 8'hCC;
            default: b = 8'hDD;
        endcase
        return {1'b0, {7{b}}};
    endfunction

    function automatic vec_t mk(input logic [3:0] valid, input logic ret,
                                input logic [3:0] ready, input logic ov,
                                input logic [1:0] src, input logic chk_d,
                                input logic [3:0] cnt, input logic err);
        vec_t v;
        v.valid = valid; v.ret = ret; v.ready = ready; v.ov = ov;
        v.src = src; v.chk_d = chk_d; v.cnt = cnt; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one row: check combinational grant before the edge, registers after.
    task automatic step(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("row%0d", idx);
        in_valid      = v.valid;
        credit_return = v.ret;
        #3;
        chk({tag, " in_ready"}, 64'(in_ready), 64'(v.ready));
        @(posedge clk);
        #1;
        chk({tag, " out_valid"}, 64'(out_valid), 64'(v.ov));
        chk({tag, " out_src"}, 64'(out_src), 64'(v.src));
        if (v.chk_d) chk({tag, " out_data"}, 64'(out_data), 64'(pat(v.src)));
        chk({tag, " credit_cnt"}, 64'(credit_cnt), 64'(v.cnt));
        chk({tag, " credit_err"}, 64'(credit_err), 64'(v.err));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, " out_data"}, 64'(out_data), 64'd0);
        chk({tag, " out_src"}, 64'(out_src), 64'd0);
        chk({tag, " credit_cnt"}, 64'(credit_cnt), 64'(CR));
        chk({tag, " credit_err"}, 64'(credit_err), 64'd0);
        chk({tag, " in_ready"}, 64'(in_ready), 64'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        //                valid    ret   ready    ov  src  chk_d cnt  err
        vecs[0]  = mk(4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'd4, 1'b0); // idle after reset
        vecs[1]  = mk(4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1, 4'd3, 1'b0); // fairness sweep
        vecs[2]  = mk(4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 4'd3, 1'b0);
        vecs[3]  = mk(4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1, 4'd3, 1'b0);
        vecs[4]  = mk(4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1, 4'd3, 1'b0);
        vecs[5]  = mk(4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 4'd3, 1'b0);
        vecs[6]  = mk(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1, 4'd4, 1'b0); // refill, src/data hold
        vecs[7]  = mk(4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b1, 4'd3, 1'b0); // single requester drains
        vecs[8]  = mk(4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b1, 4'd2, 1'b0);
        vecs[9]  = mk(4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b1, 4'd1, 1'b0);
        vecs[10] = mk(4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b1, 4'd0, 1'b0);
        vecs[11] = mk(4'b0100, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b1, 4'd0, 1'b0); // stalled at zero
        vecs[12] = mk(4'b0100, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b1, 4'd1, 1'b0); // return cannot grant same cycle
        vecs[13] = mk(4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b1, 4'd0, 1'b0); // grant next cycle
        vecs[14] = mk(4'b0100, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b1, 4'd1, 1'b0);
        vecs[15] = mk(4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1, 4'd1, 1'b0); // grant+return cancel
        vecs[16] = mk(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b1, 4'd2, 1'b0);
        vecs[17] = mk(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b1, 4'd3, 1'b0);
        vecs[18] = mk(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b1, 4'd4, 1'b0);
        vecs[19] = mk(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b1, 4'd4, 1'b1); // overflow
        vecs[20] = mk(4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b1, 4'd4, 1'b1); // sticky
        vecs[21] = mk(4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 4'd4, 1'b1); // full + grant + return
        vecs[22] = mk(4'b1111, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1, 4'd3, 1'b1);
        vecs[23] = mk(4'b1111, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b1, 4'd2, 1'b1);
        vecs[24] = mk(4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b1, 4'd1, 1'b1); // ptr now 3

        for (int p = 0; p < 4; p++) in_data[p*W +: W] = pat(2'(p));
        in_valid      = 4'b1111;
        credit_return = 1'b0;
        reset         = 1'b0;

        // Power-on reset with requests pending: nothing may be granted.
        #1 reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_reset_state("por");
        in_valid = 4'b0000;
        reset    = 1'b0;

        for (int i = 0; i < 25; i++) step(vecs[i], i);

        // Asynchronous mid-stream reset while out_valid=1 and credit_cnt=1.
        chk("pre_rst out_valid", 64'(out_valid), 64'd1);
        in_valid = 4'b1111;
        #2;
        reset = 1'b1;
        #1;
        chk_reset_state("async_rst");
        @(posedge clk);
        #1;
        chk_reset_state("rst_held");
        reset = 1'b0;

        // Pointer is back at 0, so port 0 wins the full request.
        step(mk(4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1, 4'd3, 1'b0), 100);
        step(mk(4'b1111, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1, 4'd2, 1'b0), 101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
